// File: rtl/id_stage.sv
// Decode stage: IF/ID register, 32x32 register file, main decoder, hazard detection, beq resolution, ID/EX register.
// One cycle IF/ID -> ID/EX; no EX back-pressure, the stage stalls IF itself on load-use and branch-operand hazards.
module id_stage #(
  parameter int               XLEN      = 32,
  parameter int               NREGS     = 32,
  parameter logic [XLEN-1:0]  RESET_PC4 = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc4,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  output logic            stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc4;
  logic [XLEN-1:0] rf [NREGS];

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] imm_ext, rs_data, rt_data;

  assign op      = id_instr[31:26];
  assign rs      = id_instr[25:21];
  assign rt      = id_instr[20:16];
  assign rd      = id_instr[15:11];
  assign funct   = id_instr[5:0];
  assign imm_ext = {{(XLEN-16){id_instr[15]}}, id_instr[15:0]};

  logic unused_bits;
  assign unused_bits = ^{id_instr[10:6], imm_ext[XLEN-1:XLEN-2]};

  // Write-through so an instruction in ID sees the value being written back this cycle
  assign rs_data  = (wb_we && wb_addr == rs && rs != '0) ? wb_data : rf[rs];
  assign rt_data  = (wb_we && wb_addr == rt && rt != '0) ? wb_data : rf[rt];
  assign dbg_data = rf[dbg_addr];

  logic       d_alu_src, d_mem_read, d_mem_write, d_reg_write, d_mem_to_reg;
  logic [2:0] d_alu_op;
  logic [4:0] d_rd;
  logic       is_beq, uses_rt;

  always_comb begin
    d_alu_op     = ALU_ADD;
    d_alu_src    = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_rd         = '0;
    is_beq       = 1'b0;
    uses_rt      = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        case (funct)
          6'h20: begin d_alu_op = ALU_ADD; d_reg_write = 1'b1; d_rd = rd; end
          6'h22: begin d_alu_op = ALU_SUB; d_reg_write = 1'b1; d_rd = rd; end
          6'h24: begin d_alu_op = ALU_AND; d_reg_write = 1'b1; d_rd = rd; end
          6'h25: begin d_alu_op = ALU_OR;  d_reg_write = 1'b1; d_rd = rd; end
          6'h2A: begin d_alu_op = ALU_SLT; d_reg_write = 1'b1; d_rd = rd; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        d_alu_src   = 1'b1;
        d_reg_write = 1'b1;
        d_rd        = rt;
      end
      OP_LW: begin
        d_alu_src    = 1'b1;
        d_mem_read   = 1'b1;
        d_reg_write  = 1'b1;
        d_mem_to_reg = 1'b1;
        d_rd         = rt;
      end
      OP_SW: begin
        d_alu_src   = 1'b1;
        d_mem_write = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        uses_rt = 1'b1;
      end
      default: ;
    endcase
  end

  logic load_use, br_hazard, issue;

  assign load_use = id_valid && ex_valid && ex_mem_read && ex_rd != '0 &&
                    (ex_rd == rs || (uses_rt && ex_rd == rt));
  // beq compares in ID, so any in-flight producer of its operands must drain first
  assign br_hazard = id_valid && is_beq &&
                     ((ex_valid && ex_reg_write && ex_rd != '0 && (ex_rd == rs || ex_rd == rt)) ||
                      (mem_reg_write && mem_rd != '0 && (mem_rd == rs || mem_rd == rt)));
  assign stall         = load_use || br_hazard;
  assign branch_taken  = id_valid && is_beq && !stall && (rs_data == rt_data);
  assign branch_target = id_pc4 + {imm_ext[XLEN-3:0], 2'b00};
  assign issue         = id_valid && !stall && !branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc4   <= '0;
    end else if (!stall) begin
      id_valid <= if_valid && !branch_taken;
      id_instr <= if_instr;
      id_pc4   <= if_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_pc4        <= RESET_PC4;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else begin
      ex_valid      <= issue;
      ex_pc4        <= id_pc4;
      ex_rs_data    <= rs_data;
      ex_rt_data    <= rt_data;
      ex_imm        <= imm_ext;
      ex_rs         <= rs;
      ex_rt         <= rt;
      ex_rd         <= d_rd;
      ex_alu_op     <= issue ? d_alu_op : 3'b000;
      ex_alu_src    <= issue && d_alu_src;
      ex_mem_read   <= issue && d_mem_read;
      ex_mem_write  <= issue && d_mem_write;
      ex_reg_write  <= issue && d_reg_write;
      ex_mem_to_reg <= issue && d_mem_to_reg;
    end
  end

endmodule
